// File: rtl/cordic_pkg.sv
// Shared constants, enums and helpers for the CORDIC argument pre-processor.
// Angle constants are rounded to nearest from a 124-fraction-bit pi reference.
package cordic_pkg;

    localparam int CORDIC_WIDTH     = 64;
    localparam int CORDIC_FRAC_BITS = 60;

    localparam int           PI_REF_FRAC = 124;
    localparam logic [127:0] PI_REF      = 128'h3243F6A8885A308D313198A2E0370734;

    typedef enum logic {
        ROTATION  = 1'b0,
        VECTORING = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        FOLD_NONE,
        FOLD_POS,
        FOLD_NEG
    } fold_e;

    // pi * 2^frac, rounded to nearest
    function automatic logic [127:0] pi_scaled(input int frac);
        int sh;
        sh = PI_REF_FRAC - frac;
        return (PI_REF + (128'd1 << (sh - 1))) >> sh;
    endfunction

    localparam logic [CORDIC_WIDTH-1:0] PI_HALF = CORDIC_WIDTH'(pi_scaled(CORDIC_FRAC_BITS - 1));
    localparam logic [CORDIC_WIDTH-1:0] PI      = CORDIC_WIDTH'(pi_scaled(CORDIC_FRAC_BITS));
    localparam logic [CORDIC_WIDTH-1:0] TWO_PI  = CORDIC_WIDTH'(pi_scaled(CORDIC_FRAC_BITS + 1));

    // Two's-complement negation of a w-bit value; the most negative value maps to +max.
    function automatic logic [127:0] sat_neg(input logic [127:0] v, input int w);
        logic [127:0] mask;
        logic [127:0] vmin;
        mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
        vmin = 128'd1 << (w - 1);
        if ((v & mask) == vmin)
            return vmin - 128'd1;
        return (~v + 128'd1) & mask;
    endfunction

endpackage

// File: rtl/cordic_fold_stage.sv
// Combinational quarter-turn fold: brings z inside +-pi/2 (rotation) or x to
// the right half-plane (vectoring), rotating (x,y) by the matching 90 degrees.
module cordic_fold_stage
    import cordic_pkg::*;
#(
    parameter int               WIDTH     = CORDIC_WIDTH,
    parameter logic [WIDTH-1:0] PI_HALF_Q = WIDTH'(pi_scaled(CORDIC_FRAC_BITS - 1))
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             mode,
    output logic [WIDTH-1:0] x_fold,
    output logic [WIDTH-1:0] y_fold,
    output logic [WIDTH-1:0] z_fold
);

    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic signed [WIDTH-1:0] zs;
    logic signed [WIDTH-1:0] ph;
    logic [WIDTH-1:0]        x_neg;
    logic [WIDTH-1:0]        y_neg;
    fold_e                   fold;

    assign xs    = signed'(x);
    assign ys    = signed'(y);
    assign zs    = signed'(z);
    assign ph    = signed'(PI_HALF_Q);
    assign x_neg = WIDTH'(sat_neg(128'(x), WIDTH));
    assign y_neg = WIDTH'(sat_neg(128'(y), WIDTH));

    // Vectoring with x<0 reuses the rotation transforms: y<0 is a +90 fold, y>=0 a -90 fold.
    always_comb begin
        fold = FOLD_NONE;
        if (mode_e'(mode) == ROTATION) begin
            if (zs > ph)
                fold = FOLD_POS;
            else if (zs < -ph)
                fold = FOLD_NEG;
        end else if (xs < 0) begin
            fold = (ys < 0) ? FOLD_POS : FOLD_NEG;
        end
    end

    always_comb begin
        x_fold = x;
        y_fold = y;
        z_fold = z;
        case (fold)
            FOLD_POS: begin
                x_fold = y_neg;
                y_fold = x;
                z_fold = z - PI_HALF_Q;
            end
            FOLD_NEG: begin
                x_fold = y;
                y_fold = x_neg;
                z_fold = z + PI_HALF_Q;
            end
            default: begin
                x_fold = x;
                y_fold = y;
                z_fold = z;
            end
        endcase
    end

endmodule

// File: rtl/cordic_range_reduce.sv
// Two-stage CORDIC argument pre-processor: 2pi wrap (with out-of-range clamp)
// then a 90 degree fold, feeding the core directly.
module cordic_range_reduce
    import cordic_pkg::*;
#(
    parameter int WIDTH     = CORDIC_WIDTH,
    parameter int FRAC_BITS = CORDIC_FRAC_BITS,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             mode,
    output logic             valid_out,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             mode_out,
    output logic             range_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic signed [WIDTH-1:0] Z_PI_HALF = WIDTH'(pi_scaled(FRAC_BITS - 1));
    localparam logic signed [WIDTH-1:0] Z_PI      = WIDTH'(pi_scaled(FRAC_BITS));
    localparam logic signed [WIDTH-1:0] Z_TWO_PI  = WIDTH'(pi_scaled(FRAC_BITS + 1));

    logic signed [WIDTH-1:0] z_s;
    logic signed [WIDTH-1:0] z_clamp;
    logic signed [WIDTH-1:0] z_wrap;
    logic                    z_oor;

    logic                    ld_p1;
    logic                    ld_p2;
    logic                    vld_p1;
    logic [WIDTH-1:0]        x_p1;
    logic [WIDTH-1:0]        y_p1;
    logic [WIDTH-1:0]        z_p1;
    logic                    mode_p1;
    logic                    err_p1;

    logic [WIDTH-1:0]        x_fold;
    logic [WIDTH-1:0]        y_fold;
    logic [WIDTH-1:0]        z_fold;

    assign ld_p1 = valid_in & ~flush;
    assign ld_p2 = vld_p1 & ~flush;

    // Stage 1: clamp anything beyond +-2pi to +-pi, then a single 2pi wrap suffices.
    always_comb begin
        z_s     = signed'(z);
        z_oor   = 1'b0;
        z_clamp = z_s;
        if (z_s > Z_TWO_PI) begin
            z_oor   = 1'b1;
            z_clamp = Z_PI;
        end else if (z_s < -Z_TWO_PI) begin
            z_oor   = 1'b1;
            z_clamp = -Z_PI;
        end
        z_wrap = z_clamp;
        if (z_clamp > Z_PI)
            z_wrap = z_clamp - Z_TWO_PI;
        else if (z_clamp < -Z_PI)
            z_wrap = z_clamp + Z_TWO_PI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= ld_p1;
    end

    always_ff @(posedge clk) begin
        if (ld_p1) begin
            x_p1    <= x;
            y_p1    <= y;
            z_p1    <= z_wrap;
            mode_p1 <= mode;
            err_p1  <= z_oor;
        end
    end

    // Stage 2: quarter-turn fold into the core's convergence region.
    cordic_fold_stage #(
        .WIDTH     (WIDTH),
        .PI_HALF_Q (Z_PI_HALF)
    ) u_fold (
        .x      (x_p1),
        .y      (y_p1),
        .z      (z_p1),
        .mode   (mode_p1),
        .x_fold (x_fold),
        .y_fold (y_fold),
        .z_fold (z_fold)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            mode_out  <= 1'b0;
            range_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            valid_out <= ld_p2;
            if (ld_p2) begin
                x_out     <= x_fold;
                y_out     <= y_fold;
                z_out     <= z_fold;
                mode_out  <= mode_p1;
                range_err <= err_p1;
                if (err_p1 && (err_cnt != '1))
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Directed-vector bench for cordic_range_reduce (WIDTH=64, FRAC_BITS=60).
module tb_cordic_range_reduce;

    localparam logic [63:0] ONE   = 64'h1000_0000_0000_0000;
    localparam logic [63:0] HALF  = 64'h0800_0000_0000_0000;
    localparam logic [63:0] Z2    = 64'h2000_0000_0000_0000;
    localparam logic [63:0] Z3    = 64'h3000_0000_0000_0000;
    localparam logic [63:0] Z4    = 64'h4000_0000_0000_0000;
    localparam logic [63:0] Z7    = 64'h7000_0000_0000_0000;
    localparam logic [63:0] PH    = 64'h1921FB54442D1847;
    localparam logic [63:0] PI    = 64'h3243F6A8885A308D;
    localparam logic [63:0] TP    = 64'h6487ED5110B4611A;
    localparam logic [63:0] SMIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] SMAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam int          NV    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        flush;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] z;
    logic        mode;
    logic        valid_out;
    logic [63:0] x_out;
    logic [63:0] y_out;
    logic [63:0] z_out;
    logic        mode_out;
    logic        range_err;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] z;
        logic        mode;
        logic [63:0] ex;
        logic [63:0] ey;
        logic [63:0] ez;
        logic        eerr;
    } vec_t;

    vec_t vecs [NV];

    cordic_range_reduce #(
        .WIDTH     (64),
        .FRAC_BITS (60),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .flush     (flush),
        .x         (x),
        .y         (y),
        .z         (z),
        .mode      (mode),
        .valid_out (valid_out),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .mode_out  (mode_out),
        .range_err (range_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] xi, input logic [63:0] yi,
                         input logic [63:0] zi, input logic mi);
        valid_in = v;
        x        = xi;
        y        = yi;
        z        = zi;
        mode     = mi;
    endtask

    initial begin
        // rotation: (x,y,z,mode) -> (ex,ey,ez,err)
        vecs[0]  = '{ONE,  0,     Z2,   1'b0, 0,     ONE,   Z2 - PH,       1'b0};
        vecs[1]  = '{ONE,  0,     -Z3,  1'b0, 0,     -ONE,  -Z3 + PH,      1'b0};
        vecs[2]  = '{ONE,  0,     Z4,   1'b0, 0,     -ONE,  Z4 - TP + PH,  1'b0};
        vecs[3]  = '{-ONE, HALF,  0,    1'b1, HALF,  ONE,   PH,            1'b0};
        vecs[4]  = '{-ONE, -HALF, 0,    1'b1, HALF,  -ONE,  -PH,           1'b0};
        vecs[5]  = '{ONE,  0,     Z7,   1'b0, 0,     ONE,   PI - PH,       1'b1};
        vecs[6]  = '{ONE,  0,     -Z7,  1'b0, 0,     -ONE,  -PI + PH,      1'b1};
        vecs[7]  = '{ONE,  0,     PH,   1'b0, ONE,   0,     PH,            1'b0};
        vecs[8]  = '{ONE,  0,     PI,   1'b0, 0,     ONE,   PI - PH,       1'b0};
        vecs[9]  = '{ONE,  0,     TP,   1'b0, ONE,   0,     0,             1'b0};
        vecs[10] = '{ONE,  0,     -PH,  1'b0, ONE,   0,     -PH,           1'b0};
        vecs[11] = '{ONE,  SMIN,  Z2,   1'b0, SMAX,  ONE,   Z2 - PH,       1'b0};
        vecs[12] = '{SMIN, 0,     0,    1'b1, 0,     SMAX,  PH,            1'b0};
        vecs[13] = '{ONE,  -ONE,  Z4,   1'b1, ONE,   -ONE,  Z4 - TP,       1'b0};
        vecs[14] = '{ONE,  ONE,   Z7,   1'b1, ONE,   ONE,   PI,            1'b1};
        vecs[15] = '{ONE,  0,     -PI,  1'b0, 0,     -ONE,  -PI + PH,      1'b0};

        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0);
        step();
        step();
        chk("rst.valid_out", valid_out, 0);
        chk("rst.x_out", x_out, 0);
        chk("rst.y_out", y_out, 0);
        chk("rst.z_out", z_out, 0);
        chk("rst.mode_out", mode_out, 0);
        chk("rst.range_err", range_err, 0);
        chk("rst.err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].mode);
            step();
            drive(1'b0, 0, 0, 0, 1'b0);
            chk($sformatf("vec%0d.early_valid", i), valid_out, 0);
            step();
            if (vecs[i].eerr)
                exp_cnt++;
            chk($sformatf("vec%0d.valid_out", i), valid_out, 1);
            chk($sformatf("vec%0d.x_out", i), x_out, vecs[i].ex);
            chk($sformatf("vec%0d.y_out", i), y_out, vecs[i].ey);
            chk($sformatf("vec%0d.z_out", i), z_out, vecs[i].ez);
            chk($sformatf("vec%0d.mode_out", i), mode_out, vecs[i].mode);
            chk($sformatf("vec%0d.range_err", i), range_err, vecs[i].eerr);
            chk($sformatf("vec%0d.err_cnt", i), err_cnt, exp_cnt);
            step();
            chk($sformatf("vec%0d.hold_valid", i), valid_out, 0);
            chk($sformatf("vec%0d.hold_z", i), z_out, vecs[i].ez);
        end

        // five back-to-back samples, flush alongside the second; the first one is out of range
        begin
            int tag_exp [8] = '{0, 0, 0, 0, 3, 4, 5, 0};
            for (int k = 1; k <= 7; k++) begin
                drive(k <= 5, 64'(k), 0, (k == 1) ? Z7 : 64'(k), 1'b0);
                flush = (k == 2);
                step();
                chk($sformatf("flush.e%0d.valid_out", k), valid_out, 64'(tag_exp[k] != 0));
                if (tag_exp[k] != 0) begin
                    chk($sformatf("flush.e%0d.x_out", k), x_out, 64'(tag_exp[k]));
                    chk($sformatf("flush.e%0d.z_out", k), z_out, 64'(tag_exp[k]));
                end
            end
            flush = 1'b0;
            chk("flush.err_cnt", err_cnt, exp_cnt);
        end

        // error counter: count, then saturate
        drive(1'b1, ONE, 0, Z7, 1'b0);
        for (int k = 0; k < 100; k++)
            step();
        drive(1'b0, 0, 0, 0, 1'b0);
        step();
        step();
        exp_cnt += 100;
        chk("cnt.partial", err_cnt, exp_cnt);
        drive(1'b1, ONE, 0, Z7, 1'b0);
        for (int k = 0; k < 65536; k++)
            step();
        drive(1'b0, 0, 0, 0, 1'b0);
        step();
        exp_cnt = (exp_cnt + 65536 > 65535) ? 65535 : exp_cnt + 65536;
        chk("cnt.last_range_err", range_err, 1);
        chk("cnt.last_z_out", z_out, PI - PH);
        step();
        chk("cnt.saturated", err_cnt, exp_cnt);
        step();
        chk("cnt.held", err_cnt, exp_cnt);

        // asynchronous reset with two samples in flight
        drive(1'b1, ONE, 0, Z2, 1'b0);
        step();
        drive(1'b1, ONE, 0, Z7, 1'b0);
        step();
        chk("arst.pre_valid", valid_out, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.valid_out", valid_out, 0);
        chk("arst.x_out", x_out, 0);
        chk("arst.z_out", z_out, 0);
        chk("arst.err_cnt", err_cnt, 0);
        drive(1'b0, 0, 0, 0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst.post1_valid", valid_out, 0);
        step();
        chk("arst.post2_valid", valid_out, 0);
        chk("arst.post_x_out", x_out, 0);
        chk("arst.post_y_out", y_out, 0);
        chk("arst.post_z_out", z_out, 0);
        chk("arst.post_range_err", range_err, 0);
        chk("arst.post_err_cnt", err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
